// File: rtl/mem_access_stage.sv
// Memory-access stage: request/ready data-memory transaction with lane steering and load extension.
// Optional misaligned-access trap is enabled by defining MISALIGN_TRAP_EN.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] StoreData,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] LoadData,
    output logic        mem_done,
    output logic        mem_stall,
    output logic        mem_fault
);
    localparam int unsigned CntW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e          r_state, w_state_next;
    logic [29:0]     r_addr_hi;
    logic [1:0]      r_off;
    logic [3:0]      r_be;
    logic [31:0]     r_wdata;
    logic            r_we;
    logic [2:0]      r_f3;
    logic [CntW-1:0] r_cnt;
    logic            r_fault;
    logic [31:0]     r_load_data;

    logic        w_accept, w_f3_ok, w_align_fault, w_pre_fault, w_timeout;
    logic [31:0] w_addr, w_wdata, w_load_ext;
    logic [1:0]  w_off;
    logic [3:0]  w_be;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_accept    = mem_valid & (MemRead | MemWrite);
    assign w_pre_fault = ~w_f3_ok | w_align_fault;
    assign w_off       = w_addr[1:0];
    assign w_timeout   = (r_cnt == CntLast);

    always_comb begin
        unique case (Funct3)
            3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
            3'b100, 3'b101:         w_f3_ok = ~MemWrite;
            default:                w_f3_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_addr        = ALUResult;
        w_align_fault = 1'b0;
`ifdef MISALIGN_TRAP_EN
        w_align_fault = ((Funct3[1:0] == 2'b01) && ALUResult[0]) ||
                        ((Funct3[1:0] == 2'b10) && (ALUResult[1:0] != 2'b00));
`else
        // Silently round down to natural alignment instead of trapping.
        if (Funct3[1:0] == 2'b01) begin
            w_addr[0] = 1'b0;
        end else if (Funct3[1:0] == 2'b10) begin
            w_addr[1:0] = 2'b00;
        end
`endif
    end

    always_comb begin
        case (Funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{StoreData[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << w_off;
                w_wdata = {2{StoreData[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = StoreData;
            end
        endcase
    end

    always_comb begin
        case (r_off)
            2'd0:    w_byte = dmem_rdata[7:0];
            2'd1:    w_byte = dmem_rdata[15:8];
            2'd2:    w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_f3)
            3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_ext = {24'b0, w_byte};
            3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_ext = {16'b0, w_half};
            default: w_load_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = w_pre_fault ? StDone : StReq;
                end
            end
            StReq: begin
                if (dmem_ready || w_timeout) begin
                    w_state_next = StDone;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        dmem_req   = (r_state == StReq);
        dmem_we    = dmem_req & r_we;
        dmem_addr  = dmem_req ? {r_addr_hi, 2'b00} : 32'b0;
        dmem_wdata = dmem_req ? r_wdata : 32'b0;
        dmem_be    = dmem_req ? r_be : 4'b0;
        mem_done   = (r_state == StDone);
        mem_stall  = ((r_state == StIdle) && w_accept) || (r_state == StReq);
        mem_fault  = r_fault;
        LoadData   = r_load_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr_hi   <= '0;
            r_off       <= '0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_f3        <= '0;
            r_cnt       <= '0;
            r_fault     <= 1'b0;
            r_load_data <= '0;
        end else if ((r_state == StIdle) && w_accept) begin
            r_addr_hi <= w_addr[31:2];
            r_off     <= w_off;
            r_be      <= w_be;
            r_wdata   <= w_wdata;
            r_we      <= MemWrite;
            r_f3      <= Funct3;
            r_cnt     <= '0;
            r_fault   <= w_pre_fault;
            if (w_pre_fault) begin
                r_load_data <= '0;
            end
        end else if (r_state == StReq) begin
            // Ready on the last allowed cycle still wins over the timeout.
            if (dmem_ready) begin
                if (!r_we) begin
                    r_load_data <= w_load_ext;
                end
            end else if (w_timeout) begin
                r_fault     <= 1'b1;
                r_load_data <= '0;
            end else begin
                r_cnt <= r_cnt + CntW'(1);
            end
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (TIMEOUT_CYCLES = 4).
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult, StoreData;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, LoadData;
    logic [3:0]  dmem_be;
    logic        mem_done, mem_stall, mem_fault;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [3:0]  cap_be;
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_we;

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (mem_valid),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Funct3    (Funct3),
        .ALUResult (ALUResult),
        .StoreData (StoreData),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_addr (dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_be   (dmem_be),
        .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata),
        .LoadData  (LoadData),
        .mem_done  (mem_done),
        .mem_stall (mem_stall),
        .mem_fault (mem_fault)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd);
        mem_valid = v;
        MemRead   = rd;
        MemWrite  = wr;
        Funct3    = f3;
        ALUResult = a;
        StoreData = sd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    // Accept, hold `waits` REQ cycles, complete with ready; returns in the DONE cycle.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input int waits,
                          input logic [31:0] rdata, input string tag);
        drive(1'b1, rd, wr, f3, a, sd);
        #1;
        chk1({tag, "_stall_acc"}, mem_stall, 1'b1);
        step();
        idle();
        for (int i = 0; i < waits; i++) begin
            #1;
            chk1({tag, "_req_wait"}, dmem_req, 1'b1);
            chk1({tag, "_done_wait"}, mem_done, 1'b0);
            step();
        end
        dmem_ready = 1'b1;
        dmem_rdata = rdata;
        #1;
        chk1({tag, "_req"}, dmem_req, 1'b1);
        chk1({tag, "_stall_req"}, mem_stall, 1'b1);
        cap_be    = dmem_be;
        cap_addr  = dmem_addr;
        cap_wdata = dmem_wdata;
        cap_we    = dmem_we;
        step();
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        #1;
        chk1({tag, "_done"}, mem_done, 1'b1);
        chk1({tag, "_stall_done"}, mem_stall, 1'b0);
        chk1({tag, "_req_done"}, dmem_req, 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        idle();
        step();
        step();
        chk1("rst_req", dmem_req, 1'b0);
        chk1("rst_done", mem_done, 1'b0);
        chk1("rst_stall", mem_stall, 1'b0);
        chk1("rst_fault", mem_fault, 1'b0);
        chk32("rst_load", LoadData, 32'h0);
        chk32("rst_addr", dmem_addr, 32'h0);
        rst = 1'b0;
        step();

        // SW 0x100, ready in first REQ cycle
        access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'h0, "sw");
        chk32("sw_addr", cap_addr, 32'h100);
        chk32("sw_be", {28'b0, cap_be}, 32'hF);
        chk32("sw_wdata", cap_wdata, 32'hDEADBEEF);
        chk1("sw_we", cap_we, 1'b1);
        chk1("sw_fault", mem_fault, 1'b0);
        step();
        chk1("sw_done_pulse", mem_done, 1'b0);

        // LB / LBU 0x103, three wait cycles
        access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 3, 32'h80FF1234, "lb");
        chk32("lb_load", LoadData, 32'hFFFFFF80);
        chk32("lb_be", {28'b0, cap_be}, 32'h8);
        chk32("lb_addr", cap_addr, 32'h100);
        chk1("lb_we", cap_we, 1'b0);
        step();
        chk32("lb_hold", LoadData, 32'hFFFFFF80);
        access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 3, 32'h80FF1234, "lbu");
        chk32("lbu_load", LoadData, 32'h00000080);
        step();

        // SH 0x202
        access(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 0, 32'h0, "sh");
        chk32("sh_be", {28'b0, cap_be}, 32'hC);
        chk32("sh_wdata", cap_wdata, 32'hABCDABCD);
        chk32("sh_addr", cap_addr, 32'h200);
        step();

        // LH / LHU 0x202 upper half
        access(1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 1, 32'h80FF1234, "lh");
        chk32("lh_load", LoadData, 32'hFFFF80FF);
        chk32("lh_be", {28'b0, cap_be}, 32'hC);
        step();
        access(1'b1, 1'b0, 3'b101, 32'h200, 32'h0, 0, 32'h80FF1234, "lhu");
        chk32("lhu_load", LoadData, 32'h00001234);
        step();

        // Timeout: ready held low
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        step();
        idle();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk1("to_req", dmem_req, 1'b1);
            chk1("to_done_early", mem_done, 1'b0);
            step();
        end
        chk1("to_done", mem_done, 1'b1);
        chk1("to_fault", mem_fault, 1'b1);
        chk1("to_req_off", dmem_req, 1'b0);
        chk32("to_load", LoadData, 32'h0);
        step();

        // Reserved Funct3 on a load
        drive(1'b1, 1'b1, 1'b0, 3'b011, 32'h20, 32'h0);
        #1;
        chk1("rsv_stall_acc", mem_stall, 1'b1);
        step();
        idle();
        #1;
        chk1("rsv_done", mem_done, 1'b1);
        chk1("rsv_fault", mem_fault, 1'b1);
        chk1("rsv_req", dmem_req, 1'b0);
        chk1("rsv_stall", mem_stall, 1'b0);
        step();
        chk1("rsv_done_pulse", mem_done, 1'b0);

        // Reserved Funct3 on a store (100 is load-only)
        drive(1'b1, 1'b0, 1'b1, 3'b100, 32'h20, 32'h0);
        step();
        idle();
        #1;
        chk1("rsvs_done", mem_done, 1'b1);
        chk1("rsvs_fault", mem_fault, 1'b1);
        chk1("rsvs_req", dmem_req, 1'b0);
        step();

        // LW 0x101
`ifdef MISALIGN_TRAP_EN
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
        step();
        idle();
        #1;
        chk1("mis_done", mem_done, 1'b1);
        chk1("mis_fault", mem_fault, 1'b1);
        chk1("mis_req", dmem_req, 1'b0);
        chk32("mis_load", LoadData, 32'h0);
        step();
`else
        access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 32'h12345678, "mis");
        chk32("mis_addr", cap_addr, 32'h100);
        chk32("mis_be", {28'b0, cap_be}, 32'hF);
        chk1("mis_fault", mem_fault, 1'b0);
        chk32("mis_load", LoadData, 32'h12345678);
        step();
`endif

        // Valid without read or write is ignored
        drive(1'b1, 1'b0, 1'b0, 3'b010, 32'h30, 32'h0);
        #1;
        chk1("nop_stall", mem_stall, 1'b0);
        step();
        idle();
        #1;
        chk1("nop_req", dmem_req, 1'b0);
        chk1("nop_done", mem_done, 1'b0);
        step();

        // Reset during REQ, then a fresh load
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
        step();
        idle();
        #1;
        chk1("rr_req_before", dmem_req, 1'b1);
        rst = 1'b1;
        #1;
        chk1("rr_req", dmem_req, 1'b0);
        chk1("rr_stall", mem_stall, 1'b0);
        chk1("rr_done", mem_done, 1'b0);
        step();
        rst = 1'b0;
        access(1'b1, 1'b0, 3'b010, 32'h44, 32'h0, 0, 32'hCAFEF00D, "rr_lw");
        chk32("rr_lw_load", LoadData, 32'hCAFEF00D);
        chk32("rr_lw_addr", cap_addr, 32'h44);
        chk1("rr_lw_fault", mem_fault, 1'b0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
